led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised multi-channel LED driver; successor to the single fixed-rate blinker.
- Shared prescaler derives a TICK_HZ timebase from CLK.
- Each of N_CH channels is runtime-configured to OFF, ON, BLINK (programmable half-period) or BREATHE (triangle-ramped PWM).
- Sits between the board clock and the on-board/external LED pins.
- Configured by a simple write strobe from a host FSM or UART bridge.

Parameters:
- CLK_HZ, 27_000_000: input clock frequency.
- TICK_HZ, 1_000: timebase rate. PRESCALE = CLK_HZ/TICK_HZ, must be ≥ 2.
- N_CH, 3: number of LED channels, 1..16.
- PERIOD_W, 16: width of the per-channel period register, in ticks.
- PWM_W, 8: PWM/duty resolution for BREATHE.
- DEF_PERIOD, 500: period loaded at reset.

Ports:
- CLK  in  1  board clock.
- RST  in  1  synchronous reset, active-high.
- CFG_WE  in  1  config write strobe, single cycle.
- CFG_CH  in  max(1,$clog2(N_CH))  target channel.
- CFG_MODE  in  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE.
- CFG_PERIOD  in  PERIOD_W  period in ticks.
- TICK  out  1  one-cycle timebase pulse, registered.
- LED_OUT  out  N_CH  registered LED drive, bit i = channel i.

Behaviour:
- Reset (RST high at a CLK edge):
  - prescaler=0, TICK=0, LED_OUT=0.
  - all modes=OFF, periods=DEF_PERIOD, channel counters=0, blink state=0, duty=0, direction=up, PWM counter=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - TICK=1 for exactly the cycle after the counter is at PRESCALE-1. First TICK is PRESCALE cycles after reset release.
- PWM counter:
  - Free-running PWM_W bits, +1 every CLK, shared by all channels, wraps naturally.
- Per-channel effective period P = max(CFG period, 1); a stored 0 behaves as 1.
- Channel event:
  - On each TICK the channel counter increments.
  - When the counter == P-1 it clears to 0 and raises an internal event.
  - The counter runs only in BLINK and BREATHE; it holds 0 in OFF and ON.
- OFF: LED=0.
- ON: LED=1.
- BLINK:
  - Each event toggles the blink state; LED = blink state.
  - Full blink cycle = 2·P ticks.
- BREATHE:
  - On each event, duty steps by ±1.
  - Direction is up from 0; at 2^PWM_W-1 it reverses to down; at 0 it reverses to up. Duty never wraps.
  - LED = (pwm_cnt < duty). duty=0 → constant 0; duty=max → high 255/256 of the time for PWM_W=8.
- Output latency: LED_OUT is registered, one CLK after the internal state/duty update.
- Config write (CFG_WE=1, CFG_CH<N_CH):
  - Next edge loads mode and period for that channel.
  - Also clears counter, blink state, duty and direction for that channel. Other channels are unaffected.
- CFG_CH ≥ N_CH: write ignored entirely.
- Write coincident with TICK/event on the same channel: write wins; the event is discarded.
- RST coincident with CFG_WE: reset wins.
- Rewriting identical mode/period still restarts the channel phase. This is intentional, for host resync.
- Mode change mid-pattern takes effect on the next edge, from zero phase.

Optional Feature:
- Macro: LED_ACTIVE_LOW_EN.
- Defined: LED_OUT is bitwise-inverted at the output register, for active-low board LEDs.
  - Reset value is all ones.
  - OFF drives 1, ON drives 0; BLINK/BREATHE are inverted accordingly.
- Undefined: active-high as described above. TICK is unaffected either way.

Decomposition:
- Package led_pattern_pkg:
  - Mode encodings MODE_OFF/MODE_ON/MODE_BLINK/MODE_BREATHE (2-bit).
  - Direction constants DIR_UP/DIR_DOWN.
- Sub-module led_channel: one instance per channel via generate.
  - Owns mode, period, counter, blink state, duty and direction.
  - Inputs: TICK, shared pwm_cnt, its own write strobe.
  - Output: unregistered LED level.
- Top level owns the prescaler, PWM counter, write decode and output register.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (PRESCALE=10), N_CH=3, PWM_W=4, DEF_PERIOD=3.
1. Reset released → TICK pulses at cycles 10, 20, 30… each 1 cycle wide; LED_OUT=3'b000 throughout.
2. Write ch0 BLINK P=2 → LED_OUT[0] toggles every 20 cycles (2 ticks), first toggle 1 cycle after the 2nd TICK following the write; ch1/ch2 stay 0.
3. Write ch1 BREATHE P=1 → duty 0→15→0 in 30 ticks; at duty=8 LED_OUT[1] high exactly 8 of 16 cycles; no wrap past 15 or below 0.
4. Write ch2 P=0 in BLINK → identical to P=1 (toggle every tick); then write CFG_CH=3 → no state change on any channel.
5. CFG_WE to ch0 on the same cycle as its event → no toggle; counter restarts at 0. Assert RST mid-BREATHE → all outputs 0 the next cycle, modes back to OFF.
6. Build with LED_ACTIVE_LOW_EN → after reset LED_OUT=3'b111; ch0 ON drives 0; rerun scenario 2 with inverted expectations.

Source files
------------

// File: rtl/led_pattern_gen_pkg.sv
// led_pattern_pkg: shared encodings for the LED pattern generator.
//   mode_e : per-channel operating mode (2-bit, matches CFG_MODE encoding)
//   dir_e  : BREATHE ramp direction
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_pattern_gen_channel.sv
// led_channel: one LED channel of led_pattern_gen.
// Holds the channel's mode, period, tick counter, blink state and breathe
// duty/direction. Produces an unregistered LED level; the top registers it.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   tick        shared timebase pulse
//   we          config write strobe already decoded for this channel
//   cfg_mode    mode to load on write
//   cfg_period  period (ticks) to load on write; 0 behaves as 1
//   pwm_cnt     shared free-running PWM counter
//   led         combinational LED level (active-high)
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int PERIOD_W   = 16,
    parameter int PWM_W      = 8,
    parameter int DEF_PERIOD = 500
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                tick,
    input  logic                we,
    input  mode_e               cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PWM_W-1:0]    pwm_cnt,
    output logic                led
);

    mode_e               mode;
    dir_e                dir;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cnt_last;
    logic [PWM_W-1:0]    duty;
    logic                blink;
    logic                running;

    // A stored period of 0 behaves as 1, so the wrap point is clamped to 0.
    assign cnt_last = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign running  = (mode == MODE_BLINK) || (mode == MODE_BREATHE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode   <= MODE_OFF;
            period <= PERIOD_W'(DEF_PERIOD);
            cnt    <= '0;
            blink  <= 1'b0;
            duty   <= '0;
            dir    <= DIR_UP;
        end else if (we) begin
            // A write always restarts the phase, and beats a coincident event.
            mode   <= cfg_mode;
            period <= cfg_period;
            cnt    <= '0;
            blink  <= 1'b0;
            duty   <= '0;
            dir    <= DIR_UP;
        end else if (running && tick) begin
            if (cnt == cnt_last) begin
                cnt <= '0;
                if (mode == MODE_BLINK) begin
                    blink <= ~blink;
                end else if (dir == DIR_UP) begin
                    // Reverse at the top instead of wrapping.
                    if (duty == '1) begin
                        duty <= duty - PWM_W'(1);
                        dir  <= DIR_DOWN;
                    end else begin
                        duty <= duty + PWM_W'(1);
                    end
                end else begin
                    if (duty == '0) begin
                        duty <= duty + PWM_W'(1);
                        dir  <= DIR_UP;
                    end else begin
                        duty <= duty - PWM_W'(1);
                    end
                end
            end else begin
                cnt <= cnt + PERIOD_W'(1);
            end
        end
    end

    always_comb begin
        led = 1'b0;
        case (mode)
            MODE_OFF:     led = 1'b0;
            MODE_ON:      led = 1'b1;
            MODE_BLINK:   led = blink;
            MODE_BREATHE: led = (pwm_cnt < duty);
            default:      led = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver (OFF / ON / BLINK / BREATHE).
// A shared prescaler makes a TICK_HZ timebase from CLK; a shared PWM counter
// feeds every channel; LED_OUT is registered.
// Optional feature: define LED_ACTIVE_LOW_EN to invert LED_OUT at the output
// register (reset value becomes all ones). TICK is unaffected.
// Ports:
//   CLK         board clock
//   RST         synchronous reset, active-high
//   CFG_WE      single-cycle config write strobe
//   CFG_CH      target channel; values >= N_CH are ignored
//   CFG_MODE    0=OFF 1=ON 2=BLINK 3=BREATHE
//   CFG_PERIOD  channel period in ticks
//   TICK        registered one-cycle timebase pulse
//   LED_OUT     registered LED drive, bit i = channel i
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ     = 27_000_000,
    parameter int TICK_HZ    = 1_000,
    parameter int N_CH       = 3,
    parameter int PERIOD_W   = 16,
    parameter int PWM_W      = 8,
    parameter int DEF_PERIOD = 500
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    CFG_WE,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] CFG_CH,
    input  logic [1:0]                              CFG_MODE,
    input  logic [PERIOD_W-1:0]                     CFG_PERIOD,
    output logic                                    TICK,
    output logic [N_CH-1:0]                         LED_OUT
);

    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PS_W     = $clog2(PRESCALE);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [N_CH-1:0] LED_INV = '1;
`else
    localparam logic [N_CH-1:0] LED_INV = '0;
`endif

    logic [PS_W-1:0]  presc;
    logic [PWM_W-1:0] pwm_cnt;
    logic [N_CH-1:0]  led_lvl;
    logic             presc_last;

    assign presc_last = (presc == PS_W'(PRESCALE - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc   <= '0;
            TICK    <= 1'b0;
            pwm_cnt <= '0;
            LED_OUT <= LED_INV;
        end else begin
            presc   <= presc_last ? '0 : presc + PS_W'(1);
            TICK    <= presc_last;
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            LED_OUT <= led_lvl ^ LED_INV;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_channel #(
            .PERIOD_W   (PERIOD_W),
            .PWM_W      (PWM_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .CLK        (CLK),
            .RST        (RST),
            .tick       (TICK),
            .we         (CFG_WE && (CFG_CH == CH_W'(i))),
            .cfg_mode   (mode_e'(CFG_MODE)),
            .cfg_period (CFG_PERIOD),
            .pwm_cnt    (pwm_cnt),
            .led        (led_lvl[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (PRESCALE=10, N_CH=3, PWM_W=4,
// DEF_PERIOD=3). The reference model tracks, per channel, how many ticks
// have elapsed since the last write; blink state and duty follow from that
// count arithmetically.
module tb_led_pattern_gen;

    localparam int N_CH     = 3;
    localparam int PWM_W    = 4;
    localparam int PERIOD_W = 16;
    localparam int PRESCALE = 10;
    localparam int DMAX     = (1 << PWM_W) - 1;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [N_CH-1:0] INV = '1;
`else
    localparam logic [N_CH-1:0] INV = '0;
`endif

    logic                CLK = 1'b0;
    logic                RST;
    logic                CFG_WE;
    logic [1:0]          CFG_CH;
    logic [1:0]          CFG_MODE;
    logic [PERIOD_W-1:0] CFG_PERIOD;
    logic                TICK;
    logic [N_CH-1:0]     LED_OUT;

    always #5 CLK = ~CLK;

    led_pattern_gen #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .N_CH       (N_CH),
        .PERIOD_W   (PERIOD_W),
        .PWM_W      (PWM_W),
        .DEF_PERIOD (3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CFG_WE     (CFG_WE),
        .CFG_CH     (CFG_CH),
        .CFG_MODE   (CFG_MODE),
        .CFG_PERIOD (CFG_PERIOD),
        .TICK       (TICK),
        .LED_OUT    (LED_OUT)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              e;                // clock edges since reset release
    int              m_mode  [N_CH];
    int              m_p     [N_CH];   // effective period (>= 1)
    int              m_ticks [N_CH];   // ticks counted since last write
    logic            exp_tick;
    logic [N_CH-1:0] exp_led;

    function automatic logic tick_now();
        return (e > 0) && (e % PRESCALE == 0);
    endfunction

    function automatic int events(int i);
        return m_ticks[i] / m_p[i];
    endfunction

    function automatic int duty_of(int i);
        int k;
        k = events(i) % (2 * DMAX);
        return (k <= DMAX) ? k : 2 * DMAX - k;
    endfunction

    function automatic logic level(int i, int pwm);
        case (m_mode[i])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (events(i) % 2) == 1;
            default: return pwm < duty_of(i);
        endcase
    endfunction

    task automatic model_reset();
        e = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_mode[i]  = 0;
            m_p[i]     = 3;
            m_ticks[i] = 0;
        end
        exp_led  = INV;
        exp_tick = 1'b0;
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance one clock: predict from pre-edge state and current inputs,
    // then compare DUT outputs 1 time unit after the edge.
    task automatic step();
        logic [N_CH-1:0] nl;
        logic            tk;
        int              pwm;
        if (RST) begin
            model_reset();
        end else begin
            tk  = tick_now();
            pwm = e % (1 << PWM_W);
            for (int i = 0; i < N_CH; i++) nl[i] = level(i, pwm);
            exp_led = nl ^ INV;
            for (int i = 0; i < N_CH; i++) begin
                if (CFG_WE && (int'(CFG_CH) == i)) begin
                    m_mode[i]  = int'(CFG_MODE);
                    m_p[i]     = (CFG_PERIOD == 0) ? 1 : int'(CFG_PERIOD);
                    m_ticks[i] = 0;
                end else if (tk && m_mode[i] >= 2) begin
                    m_ticks[i]++;
                end
            end
            e++;
            exp_tick = (e % PRESCALE == 0);
        end
        @(posedge CLK);
        #1;
        check("led_out", 8'(LED_OUT), 8'(exp_led));
        check("tick", 8'(TICK), 8'(exp_tick));
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(int ch, int mode, int per);
        CFG_WE     = 1'b1;
        CFG_CH     = 2'(ch);
        CFG_MODE   = 2'(mode);
        CFG_PERIOD = PERIOD_W'(per);
        step();
        CFG_WE     = 1'b0;
    endtask

    initial begin
        int n;
        int hi;
        RST = 1'b1; CFG_WE = 1'b0; CFG_CH = '0; CFG_MODE = '0; CFG_PERIOD = '0;
        model_reset();
        steps(3);
        RST = 1'b0;

        // Timebase and idle outputs
        steps(35);

        // ch0 BLINK P=2
        wr(0, 2, 2);
        steps(60);

        // ch1 BREATHE P=1: full 0->15->0 ramp and beyond
        wr(1, 3, 1);
        steps(320);

        // ch2 BLINK with P=0 behaves as P=1; out-of-range channel ignored
        wr(2, 2, 0);
        steps(40);
        wr(3, 1, 5);
        steps(30);

        // Write to ch0 on the very edge of its event
        n = 0;
        while (!(tick_now() && m_mode[0] == 2 && ((m_ticks[0] + 1) % m_p[0]) == 0) && n < 200) begin
            step();
            n++;
        end
        check("collision_wait", 8'(n < 200), 8'(1));
        wr(0, 2, 2);
        steps(50);

        // BREATHE duty=8 gives exactly 8 of 16 PWM cycles high
        wr(1, 3, 4);
        n = 0;
        while (events(1) != 8 && n < 600) begin
            step();
            n++;
        end
        check("duty8_wait", 8'(n < 600), 8'(1));
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            hi += int'(LED_OUT[1] ^ INV[1]);
        end
        check("duty8_high_count", 8'(hi), 8'(8));

        // Reset in the middle of BREATHE
        RST = 1'b1;
        step();
        RST = 1'b0;
        steps(25);

        // ch0 ON
        wr(0, 1, 7);
        steps(5);

        // Randomized writes, occasional reset
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                RST = 1'b1;
                step();
                RST = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
